fifo_prog: RTL and testbench

- Parametrised synchronous FIFO with single-clock write and read ports.
- Generalises the team's 16x8 FIFO in four ways: any depth (non-power-of-2 included), selectable standard or first-word-fall-through (FWFT) read mode, run-time almost-full/almost-empty thresholds, and an occupancy count output.
- Sits between producer and consumer blocks; flag semantics are unchanged, so existing UVM agents can drive it.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_ptr.sv | 25 ++
 rtl/fifo_prog.sv | 131 +++++++++++++
 tb/tb_fifo_prog.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types, defaults and pointer-wrap helper for the programmable FIFO.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    // Wrap by explicit compare so non-power-of-2 depths stay in range.
    function automatic int next_ptr(input int ptr, input int depth);
        return (ptr == depth - 32'sd1) ? 32'sd0 : ptr + 32'sd1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer register used for both the write and the read side.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_DEPTH,
    localparam int PTR_W = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    // Pointer advances on each accepted access and wraps at FIFO_DEPTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= {PTR_W{1'b0}};
        end else if (inc) begin
            ptr <= PTR_W'(next_ptr(int'(ptr), FIFO_DEPTH));
        end else begin
            ptr <= ptr;
        end
    end

endmodule

// File: rtl/fifo_prog.sv
// Parametrised single-clock FIFO: any depth, standard or FWFT read,
// run-time almost-full/almost-empty thresholds and an occupancy count.
module fifo_prog
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_WIDTH,
    parameter int FIFO_DEPTH = DEF_DEPTH,
    parameter int FWFT       = 0,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [CNT_W-1:0]      af_level,
    input  logic [CNT_W-1:0]      ae_level,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    logic [FIFO_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_s;
    logic [PTR_W-1:0]      rd_ptr_s;
    logic [CNT_W-1:0]      count_r;
    logic                  wa_s;
    logic                  ra_s;
    logic                  wr_ack_r;
    logic                  overflow_r;
    logic                  underflow_r;

    // Accept decisions look only at the registered occupancy flags.
    assign wa_s = wr_en && !full;
    assign ra_s = rd_en && !empty;

    fifo_ptr #(.FIFO_DEPTH(FIFO_DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wa_s),
        .ptr   (wr_ptr_s)
    );

    fifo_ptr #(.FIFO_DEPTH(FIFO_DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ra_s),
        .ptr   (rd_ptr_s)
    );

    // Storage write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wa_s) begin
            mem_r[wr_ptr_s] <= data_in;
        end
    end

    // Occupancy: simultaneous accepted write and read cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({wa_s, ra_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Handshake pulses reflect the previous cycle's requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack_r    <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wr_ack_r    <= wa_s;
            overflow_r  <= wr_en && full;
            underflow_r <= rd_en && empty;
        end
    end

    assign count       = count_r;
    assign wr_ack      = wr_ack_r;
    assign overflow    = overflow_r;
    assign underflow   = underflow_r;
    assign full        = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty       = (count_r == {CNT_W{1'b0}});
    assign almostfull  = (count_r >= af_level);
    assign almostempty = !empty && (count_r <= ae_level);

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            // Head word shown directly; masked while empty so nothing unwritten leaks out.
            assign data_out   = empty ? {FIFO_WIDTH{1'b0}} : mem_r[rd_ptr_s];
            assign data_valid = !empty;
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] data_out_r;
            logic                  data_valid_r;

            // Registered read: popped word lands one cycle after the accepted read.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_out_r   <= {FIFO_WIDTH{1'b0}};
                    data_valid_r <= 1'b0;
                end else if (ra_s) begin
                    data_out_r   <= mem_r[rd_ptr_s];
                    data_valid_r <= 1'b1;
                end else begin
                    data_out_r   <= data_out_r;
                    data_valid_r <= 1'b0;
                end
            end

            assign data_out   = data_out_r;
            assign data_valid = data_valid_r;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_prog.sv
// Directed bench: depth-8 standard, depth-6 standard and depth-8 FWFT instances.
module tb_fifo_prog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic rst_n;
    logic c_rst_n;

    logic [15:0] a_din, a_dout;
    logic        a_wr, a_rd, a_dv, a_ack, a_ovf, a_udf, a_full, a_empty, a_afull, a_aempty;
    logic [3:0]  a_af, a_ae, a_cnt;

    logic [15:0] b_din, b_dout;
    logic        b_wr, b_rd, b_dv, b_ack, b_ovf, b_udf, b_full, b_empty, b_afull, b_aempty;
    logic [2:0]  b_af, b_ae, b_cnt;

    logic [15:0] c_din, c_dout;
    logic        c_wr, c_rd, c_dv, c_ack, c_ovf, c_udf, c_full, c_empty, c_afull, c_aempty;
    logic [3:0]  c_af, c_ae, c_cnt;

    fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .data_in(a_din), .wr_en(a_wr), .rd_en(a_rd),
        .af_level(a_af), .ae_level(a_ae), .data_out(a_dout), .data_valid(a_dv),
        .wr_ack(a_ack), .overflow(a_ovf), .underflow(a_udf), .full(a_full),
        .empty(a_empty), .almostfull(a_afull), .almostempty(a_aempty), .count(a_cnt)
    );

    fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(6), .FWFT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .data_in(b_din), .wr_en(b_wr), .rd_en(b_rd),
        .af_level(b_af), .ae_level(b_ae), .data_out(b_dout), .data_valid(b_dv),
        .wr_ack(b_ack), .overflow(b_ovf), .underflow(b_udf), .full(b_full),
        .empty(b_empty), .almostfull(b_afull), .almostempty(b_aempty), .count(b_cnt)
    );

    fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) u_c (
        .clk(clk), .rst_n(c_rst_n), .data_in(c_din), .wr_en(c_wr), .rd_en(c_rd),
        .af_level(c_af), .ae_level(c_ae), .data_out(c_dout), .data_valid(c_dv),
        .wr_ack(c_ack), .overflow(c_ovf), .underflow(c_udf), .full(c_full),
        .empty(c_empty), .almostfull(c_afull), .almostempty(c_aempty), .count(c_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [27:0] got, exp;
        rst_n = 1'b0; c_rst_n = 1'b0;
        a_din = 16'h0; a_wr = 1'b0; a_rd = 1'b0; a_af = 4'd6; a_ae = 4'd2;
        b_din = 16'h0; b_wr = 1'b0; b_rd = 1'b0; b_af = 3'd5; b_ae = 3'd1;
        c_din = 16'h0; c_wr = 1'b0; c_rd = 1'b0; c_af = 4'd8; c_ae = 4'd1;
        repeat (2) tick();
        got = {a_empty, a_full, a_afull, a_aempty, a_cnt, a_dv, a_ack, a_ovf, a_udf, a_dout};
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_a got %h exp %h", got, exp); end
        checks++;
        if ({c_empty, c_cnt, c_dv, c_dout} !== {1'b1, 4'd0, 1'b0, 16'h0000}) begin
            errors++; $display("FAIL reset_c got %h exp %h", {c_empty, c_cnt, c_dv, c_dout}, 22'h200000);
        end
        a_af = 4'd0; #1;
        checks++;
        if (a_afull !== 1'b1) begin errors++; $display("FAIL reset_af0 got %b exp 1", a_afull); end
        a_af = 4'd6;
        rst_n = 1'b1; c_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        logic [8:0] got, exp;
        for (int i = 1; i <= 8; i++) begin
            a_wr = 1'b1; a_din = 16'(i);
            tick();
            got = {a_ack, a_ovf, a_cnt, a_full, a_afull, a_aempty};
            exp = {1'b1, 1'b0, 4'(i), (i == 8), (i >= 6), (i <= 2)};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL fill_%0d got %b exp %b", i, got, exp); end
            if (i == 6) begin
                a_af = 4'd7; #1;
                checks++;
                if (a_afull !== 1'b0) begin errors++; $display("FAIL af_change got %b exp 0", a_afull); end
                a_af = 4'd6;
            end
        end
        a_din = 16'h0009;
        tick();
        a_wr = 1'b0;
        checks++;
        if ({a_ack, a_ovf, a_cnt, a_full} !== {1'b0, 1'b1, 4'd8, 1'b1}) begin
            errors++; $display("FAIL overflow got %b exp 01" , {a_ack, a_ovf, a_cnt, a_full});
        end
    endtask

    task automatic test_full_rw();
        a_wr = 1'b1; a_rd = 1'b1; a_din = 16'h00AA;
        tick();
        a_wr = 1'b0; a_rd = 1'b0;
        checks++;
        if ({a_dout, a_dv, a_ovf, a_ack, a_cnt} !== {16'h0001, 1'b1, 1'b1, 1'b0, 4'd7}) begin
            errors++; $display("FAIL full_rw got %h exp %h", {a_dout, a_dv, a_ovf, a_ack, a_cnt}, {16'h0001, 1'b1, 1'b1, 1'b0, 4'd7});
        end
        tick();
        checks++;
        if ({a_dout, a_dv, a_ovf} !== {16'h0001, 1'b0, 1'b0}) begin
            errors++; $display("FAIL hold got %h exp %h", {a_dout, a_dv, a_ovf}, {16'h0001, 2'b00});
        end
    endtask

    task automatic test_drain();
        logic [21:0] got, exp;
        for (int i = 2; i <= 8; i++) begin
            a_rd = 1'b1;
            tick();
            got = {a_dout, a_dv, a_cnt, a_aempty};
            exp = {16'(i), 1'b1, 4'(8 - i), ((8 - i) >= 1 && (8 - i) <= 2)};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL drain_%0d got %h exp %h", i, got, exp); end
        end
        a_rd = 1'b0;
        checks++;
        if (a_empty !== 1'b1) begin errors++; $display("FAIL drained_empty got %b exp 1", a_empty); end
    endtask

    task automatic test_underflow();
        a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
        checks++;
        if ({a_udf, a_dv, a_cnt} !== {1'b1, 1'b0, 4'd0}) begin
            errors++; $display("FAIL underflow got %b exp 100000", {a_udf, a_dv, a_cnt});
        end
        a_wr = 1'b1; a_rd = 1'b1; a_din = 16'h0055;
        tick();
        a_wr = 1'b0; a_rd = 1'b0;
        checks++;
        if ({a_ack, a_udf, a_dv, a_cnt} !== {1'b1, 1'b1, 1'b0, 4'd1}) begin
            errors++; $display("FAIL empty_rw got %b exp 1100001", {a_ack, a_udf, a_dv, a_cnt});
        end
        a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
        checks++;
        if ({a_dout, a_dv, a_cnt, a_empty} !== {16'h0055, 1'b1, 4'd0, 1'b1}) begin
            errors++; $display("FAIL empty_rw_read got %h exp %h", {a_dout, a_dv, a_cnt, a_empty}, {16'h0055, 1'b1, 4'd0, 1'b1});
        end
    endtask

    task automatic test_wrap();
        logic [15:0] q[$];
        logic [15:0] exp_d;
        int mcnt = 0;
        logic wr, rd, wa, ra;
        for (int k = 0; k < 26; k++) begin
            wr = (k < 20) && (k % 3 != 2);
            rd = (k >= 20) || (k % 2 == 1);
            wa = wr && (mcnt < 6);
            ra = rd && (mcnt > 0);
            b_wr = wr; b_rd = rd; b_din = 16'h0100 + 16'(k);
            exp_d = 16'h0;
            if (ra) exp_d = q.pop_front();
            if (wa) q.push_back(b_din);
            mcnt = mcnt + int'(wa) - int'(ra);
            tick();
            checks++;
            if (b_cnt !== 3'(mcnt)) begin errors++; $display("FAIL wrap_cnt_%0d got %0d exp %0d", k, b_cnt, mcnt); end
            checks++;
            if (ra ? ({b_dv, b_dout} !== {1'b1, exp_d}) : (b_dv !== 1'b0)) begin
                errors++; $display("FAIL wrap_data_%0d got %b/%h exp %b/%h", k, b_dv, b_dout, ra, exp_d);
            end
        end
        b_wr = 1'b0; b_rd = 1'b0;
        checks++;
        if (b_empty !== (mcnt == 0)) begin errors++; $display("FAIL wrap_end got %b exp %b", b_empty, (mcnt == 0)); end
    endtask

    task automatic test_fwft();
        c_wr = 1'b1; c_din = 16'hBEEF;
        tick();
        c_wr = 1'b0;
        checks++;
        if ({c_dout, c_dv, c_cnt} !== {16'hBEEF, 1'b1, 4'd1}) begin
            errors++; $display("FAIL fwft_first got %h exp %h", {c_dout, c_dv, c_cnt}, {16'hBEEF, 1'b1, 4'd1});
        end
        c_wr = 1'b1; c_din = 16'h1234;
        tick();
        c_wr = 1'b0;
        checks++;
        if ({c_dout, c_cnt} !== {16'hBEEF, 4'd2}) begin
            errors++; $display("FAIL fwft_second got %h exp %h", {c_dout, c_cnt}, {16'hBEEF, 4'd2});
        end
        c_rd = 1'b1;
        tick();
        c_rd = 1'b0;
        checks++;
        if ({c_dout, c_dv, c_cnt} !== {16'h1234, 1'b1, 4'd1}) begin
            errors++; $display("FAIL fwft_pop got %h exp %h", {c_dout, c_dv, c_cnt}, {16'h1234, 1'b1, 4'd1});
        end
        c_wr = 1'b1; c_din = 16'h5678;
        tick();
        c_wr = 1'b0;
        #2;
        c_rst_n = 1'b0;
        #1;
        checks++;
        if ({c_empty, c_cnt, c_dv, c_dout, c_ack} !== {1'b1, 4'd0, 1'b0, 16'h0000, 1'b0}) begin
            errors++; $display("FAIL fwft_midreset got %h exp %h", {c_empty, c_cnt, c_dv, c_dout, c_ack}, {1'b1, 4'd0, 1'b0, 16'h0000, 1'b0});
        end
        tick();
        c_rst_n = 1'b1;
        tick();
        checks++;
        if ({c_empty, c_dv} !== 2'b10) begin errors++; $display("FAIL fwft_after_reset got %b exp 10", {c_empty, c_dv}); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_rw();
        test_drain();
        test_underflow();
        test_wrap();
        test_fwft();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
